multi_counter: RTL
==================

Name: multi_counter

Overview:
Parametrised, multi-channel successor to the single up-counter. It provides NCH independent counters of WIDTH bits. Each channel adds up/down counting, synchronous load, a per-channel wrap or saturate mode, and a registered terminal-count pulse. It sits beside control FSMs and timers as a shared event and timeout counter bank.

Parameters:
WIDTH, 8, counter width in bits per channel (>=2)
NCH, 4, number of independent channels (>=1)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
en  input  1  global step enable; clr/load act regardless of en
clr  input  NCH  per-channel synchronous clear
load  input  NCH  per-channel synchronous load
inc  input  NCH  per-channel count-up request
dec  input  NCH  per-channel count-down request
sat_mode  input  NCH  per channel: 1 = saturate at bounds, 0 = wrap
load_val  input  NCH*WIDTH  load values, channel i at [i*WIDTH +: WIDTH]
max_val  input  NCH*WIDTH  upper bound per channel, same packing
cnt  output  NCH*WIDTH  registered count per channel, same packing
eq  output  NCH  combinational: cnt[i] == max_val[i]
tc  output  NCH  registered one-cycle terminal-count pulse
any_tc  output  1  registered OR of next-cycle tc (aligned with tc)

Behaviour:
- Reset (rst high, async): all cnt = 0, tc = 0, any_tc = 0. eq follows its combinational definition.
- Channels are fully independent. Channel i uses only bit i or slice i of each input.
- Priority per channel, evaluated each rising clk edge: clr > load > step > hold.
- clr: cnt <= 0; tc <= 0.
- load: cnt <= min(load_val, max_val), so an oversize load is clamped to max_val; tc <= 0.
- Step is active when en=1 and exactly one of inc/dec is 1. inc=dec=1 means hold, with tc <= 0.
- Up step:
  - If cnt < max_val: cnt <= cnt+1, tc <= 0.
  - If cnt >= max_val, the boundary applies. Wrap mode: cnt <= 0, tc <= 1. Saturate mode: cnt <= max_val, tc <= 1.
- Down step:
  - If cnt > max_val (max_val lowered while counting): cnt <= max_val, tc <= 0.
  - Else if cnt > 0: cnt <= cnt-1, tc <= 0.
  - If cnt == 0, the boundary applies. Wrap mode: cnt <= max_val, tc <= 1. Saturate mode: cnt holds 0, tc <= 1.
- No step: cnt holds, tc <= 0. tc is never high for two consecutive cycles unless a boundary step repeats (e.g. saturate with inc held).
- Arithmetic is unsigned WIDTH-bit. cnt+1 at cnt = 2^WIDTH-1 cannot occur, because max_val <= 2^WIDTH-1 forces the boundary path.
- max_val == 0:
  - Wrap mode: every up or down step yields cnt = 0 with tc = 1.
  - Saturate mode: cnt stays 0 and tc pulses on each step.
- Latency: cnt and tc update one cycle after the request edge. any_tc equals the OR of the tc bits in the same cycle.
- sat_mode and max_val may change at any time; they take effect on the next edge.
- Reset asserted mid-count clears immediately. The first step after rst deasserts uses cnt = 0.

Decomposition:
- Package multi_counter_pkg holds the mode encoding constants MODE_WRAP=0 and MODE_SAT=1.
- It also holds a helper function for the clamp min(a,b).
- Sub-module counter_chan implements one channel: scalar ports plus WIDTH parameter, with outputs cnt, eq and tc.
- The top level instantiates NCH copies in a generate loop, slices the packed buses, and registers any_tc.

Test Plan:
1. Reset and eq: WIDTH=8, NCH=4. Assert rst mid-count (ch0 cnt=37) -> cnt0=0 immediately, tc=0, any_tc=0. With max_val0=0, eq[0]=1.
2. Up wrap: max_val0=5, sat=0, inc0 held 7 cycles -> cnt0 goes 1,2,3,4,5,0,1. tc0 pulses exactly in the cycle cnt0 shows 0, and any_tc pulses in the same cycle.
3. Saturate and down: max_val1=3, sat=1, inc1 held 5 cycles -> cnt1 goes 1,2,3,3,3 with tc1=1 on the last two. Then dec1 held 5 cycles -> 2,1,0,0,0 with tc1=1 on the last two.
4. Priority and clamp: ch2 at cnt=4 with max_val=10. clr+load+inc in the same cycle -> cnt2=0. Then load=1, load_val=200 -> cnt2=10 and eq[2]=1. Then inc=dec=1 -> cnt2 holds 10, tc2=0.
5. Global enable: en=0 with inc3=1 for 4 cycles -> cnt3 unchanged. With en=0 and load3=1, load_val=7 -> cnt3=7, showing load ignores en.
6. Down wrap and lowered max: max_val0=9, sat=0, cnt0=0, dec0 -> cnt0=9, tc0=1. Then set max_val0=4 and dec0 -> cnt0=4 (clamp step, tc0=0).

Source files
------------

// File: rtl/multi_counter_pkg.sv
// multi_counter_pkg: shared mode encoding and clamp helper
// for the multi-channel counter bank.
package multi_counter_pkg;

  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  // Widths up to 32 bits; callers zero-extend and truncate.
  function automatic logic [31:0] min_u(
    input logic [31:0] a,
    input logic [31:0] b
  );
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/counter_chan.sv
// counter_chan: one up/down channel with load, clear,
// wrap/saturate boundary handling and a registered tc pulse.
module counter_chan
  import multi_counter_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             load,
  input  logic             inc,
  input  logic             dec,
  input  logic             sat_mode,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] max_val,
  output logic [WIDTH-1:0] cnt,
  output logic             eq,
  output logic             tc,
  output logic             tc_nxt
);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             tc_q, tc_d;
  logic [WIDTH-1:0] ld_v;
  logic             up, dn, sat;

  assign ld_v = WIDTH'(min_u(32'(load_val), 32'(max_val)));
  assign up   = en & inc & ~dec;
  assign dn   = en & dec & ~inc;
  assign sat  = (sat_mode == MODE_SAT);

  always_comb begin
    cnt_d = cnt_q;
    tc_d  = 1'b0;
    if (clr) begin
      cnt_d = '0;
    end else if (load) begin
      cnt_d = ld_v;
    end else if (up) begin
      if (cnt_q < max_val) begin
        cnt_d = cnt_q + WIDTH'(1);
      end else begin
        cnt_d = sat ? max_val : '0;
        tc_d  = 1'b1;
      end
    end else if (dn) begin
      // max_val may have been lowered below the count
      if (cnt_q > max_val) begin
        cnt_d = max_val;
      end else if (cnt_q != '0) begin
        cnt_d = cnt_q - WIDTH'(1);
      end else begin
        cnt_d = sat ? '0 : max_val;
        tc_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      tc_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tc_q  <= tc_d;
    end
  end

  assign cnt    = cnt_q;
  assign tc     = tc_q;
  assign tc_nxt = tc_d;
  assign eq     = (cnt_q == max_val);

endmodule

// File: rtl/multi_counter.sv
// multi_counter: NCH independent counter_chan instances
// with a registered any-terminal-count flag.
module multi_counter
  import multi_counter_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NCH   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [NCH-1:0]       clr,
  input  logic [NCH-1:0]       load,
  input  logic [NCH-1:0]       inc,
  input  logic [NCH-1:0]       dec,
  input  logic [NCH-1:0]       sat_mode,
  input  logic [NCH*WIDTH-1:0] load_val,
  input  logic [NCH*WIDTH-1:0] max_val,
  output logic [NCH*WIDTH-1:0] cnt,
  output logic [NCH-1:0]       eq,
  output logic [NCH-1:0]       tc,
  output logic                 any_tc
);

  logic [NCH-1:0] tc_d;
  logic           any_tc_q;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    counter_chan #(
      .WIDTH(WIDTH)
    ) u_chan (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .clr      (clr[i]),
      .load     (load[i]),
      .inc      (inc[i]),
      .dec      (dec[i]),
      .sat_mode (sat_mode[i]),
      .load_val (load_val[i*WIDTH +: WIDTH]),
      .max_val  (max_val[i*WIDTH +: WIDTH]),
      .cnt      (cnt[i*WIDTH +: WIDTH]),
      .eq       (eq[i]),
      .tc       (tc[i]),
      .tc_nxt   (tc_d[i])
    );
  end

  // Registered from next-state tc so it lines up with tc
  always_ff @(posedge clk or posedge rst) begin
    if (rst) any_tc_q <= 1'b0;
    else     any_tc_q <= |tc_d;
  end

  assign any_tc = any_tc_q;

endmodule
